// File: rtl/spi_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_receiver_if
// Description : Bundles the SPI pins and the frame-receiver outputs.
//               master : drives the SPI pins (sck, sdi, cs_n) and observes
//                        the displayed frame and the done/error pulses.
//               slave  : the receiver itself.
//               matrix : 32 words x 16 bits, word 0 first.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_frame_receiver_if;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic [15:0] matrix [31:0];
    logic        frame_done;
    logic        frame_err;

    modport master (
        output sck, sdi, cs_n,
        input  matrix, frame_done, frame_err
    );

    modport slave (
        input  sck, sdi, cs_n,
        output matrix, frame_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_receiver
// Description : Receives a 512-bit SPI (mode 0, MSB first) frame into a
//               staging buffer and copies it to the displayed matrix in a
//               single cycle once all 512 bits have arrived.
// Ports       : clk    - system clock (all logic on posedge)
//               reset  - synchronous active-high reset
//               bus    - slave modport: sck/sdi/cs_n in,
//                        matrix/frame_done/frame_err out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            clk,
    input  wire logic            reset,
    spi_frame_receiver_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] c_FLUSH = 2'(SYNC_STAGES);

    // Synchronizer chains; the last stage is the synchronized value.
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;

    // Counts cycles after reset until the chains hold real input samples.
    logic [1:0]  flush_q, flush_d;
    // Set once cs_n has been seen high after reset; a cs_n that was already
    // low through reset therefore cannot open a transfer.
    logic        armed_q, armed_d;

    state_t      state_q, state_d;
    logic [8:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] staging_q [31:0];
    logic [15:0] staging_d [31:0];
    logic [15:0] matrix_q  [31:0];
    logic [15:0] matrix_d  [31:0];
    logic        copy_q, copy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        w_sck_s;
    logic        w_sdi_s;
    logic        w_cs_s;
    logic        w_sck_rise;
    logic [7:0]  w_new_byte;
    logic [5:0]  w_byte_idx;
    logic [4:0]  w_word_idx;

    assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign w_sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign w_cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~sck_prev_q;
    assign w_new_byte = {shift_q[6:0], w_sdi_s};
    assign w_byte_idx = bit_cnt_q[8:3];
    assign w_word_idx = w_byte_idx[5:1];

    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
        sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  bus.cs_n};
        sck_prev_d = w_sck_s;
        flush_d    = (flush_q != c_FLUSH) ? flush_q + 2'd1 : flush_q;
        armed_d    = armed_q | ((flush_q == c_FLUSH) & w_cs_s);

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        staging_d  = staging_q;
        matrix_d   = matrix_q;
        copy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        // Copy happens the cycle after the last byte lands in staging, so the
        // new frame and frame_done appear together two cycles after the
        // final edge detect.
        if (copy_q) begin
            matrix_d = staging_q;
            done_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !w_cs_s) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 9'd0;
                end
            end
            ST_RECV: begin
                // cs_n release takes priority over a coincident sck edge.
                if (w_cs_s) begin
                    err_d     = 1'b1;
                    bit_cnt_d = 9'd0;
                    state_d   = ST_IDLE;
                end else if (w_sck_rise) begin
                    shift_d   = w_new_byte;
                    bit_cnt_d = bit_cnt_q + 9'd1;
                    if (bit_cnt_q[2:0] == 3'b111) begin
                        if (w_byte_idx[0]) begin
                            staging_d[w_word_idx][7:0]  = w_new_byte;
                        end else begin
                            staging_d[w_word_idx][15:8] = w_new_byte;
                        end
                    end
                    if (bit_cnt_q == 9'd511) begin
                        copy_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            flush_q    <= 2'd0;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 9'd0;
            shift_q    <= 8'd0;
            staging_q  <= '{default: 16'h0000};
            matrix_q   <= '{default: 16'h0000};
            copy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            sdi_sync_q <= sdi_sync_d;
            cs_sync_q  <= cs_sync_d;
            sck_prev_q <= sck_prev_d;
            flush_q    <= flush_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            staging_q  <= staging_d;
            matrix_q   <= matrix_d;
            copy_q     <= copy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.matrix     = matrix_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;

endmodule
`default_nettype wire

// File: doc/spi_frame_receiver.md
SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on each SPI input (legal range 2..3).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk; one clock; the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sck  input  1  SPI clock from MCU, asynchronous to clk, mode 0, frequency at most clk/8.
REQ-005 SHALL have port sdi  input  1  SPI data from MCU, MSB first, stable around sck rising edge.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active low, frames one transfer.
REQ-007 SHALL have port matrix  output  16 x 32 (unpacked [31:0] of [15:0])  displayed frame; drives the display interface matrix input directly.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse in the first cycle a new frame is visible on matrix.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a transfer ends short of a full frame.

Function
REQ-010 SHALL pass sck, sdi and cs_n each through a SYNC_STAGES-flop synchronizer; all logic below uses only synchronized versions.
REQ-011 SHALL detect an sck rising edge as synchronized sck = 1 with its previous-cycle value = 0; the detect is high for exactly one clk cycle per edge.
REQ-012 SHALL use a 3-state FSM: IDLE, RECV, HOLD.
REQ-013 IDLE: on synchronized cs_n = 0 go to RECV with bit counter = 0; sck edges in IDLE are ignored.
REQ-014 RECV: on each sck edge shift sdi into an 8-bit shift register and increment a 9-bit bit counter (0..511).
REQ-015 SHALL write each completed byte (bit counter multiple of 8) into a 512-bit staging buffer.
REQ-016 Byte k (0..63) SHALL map to staging word k/2: even k fills bits [15:8], odd k fills bits [7:0]. The first bit received in a byte SHALL land in the higher-numbered bit.
REQ-017 When the 512th bit is received, SHALL copy the whole staging buffer into matrix in a single cycle and go to HOLD.
REQ-018 The new frame SHALL be visible on matrix, with frame_done = 1, exactly 2 clk cycles after the cycle in which the 512th sck edge detect is high.
REQ-019 matrix SHALL change only on a full-frame copy; it never shows a partially received frame.
REQ-020 RECV: synchronized cs_n = 1 before 512 bits SHALL:
  - pulse frame_err for one cycle;
  - leave matrix unchanged;
  - discard partial data;
  - go to IDLE.
REQ-021 HOLD: sck edges SHALL be ignored (extra bits dropped, no error); synchronized cs_n = 1 returns to IDLE.
REQ-022 If cs_n rising and an sck edge are detected in the same cycle in RECV, cs_n SHALL win and the bit is dropped.
REQ-023 The staging buffer need not be cleared between frames; every word is overwritten before a copy.
REQ-024 frame_done and frame_err SHALL never both be high in one cycle.
REQ-025 Back-to-back frames (cs_n high for at least SYNC_STAGES+1 clk) SHALL each produce exactly one frame_done.

Reset
REQ-026 While reset = 1 at posedge clk, the block SHALL set:
  - FSM = IDLE;
  - bit counter, shift register, staging buffer and all 32 matrix words = 0;
  - frame_done = frame_err = 0;
  - synchronizer flops: sck to 0, cs_n to 1.
REQ-027 Reset asserted mid-transfer SHALL abort without a frame_err pulse. After release, the block SHALL wait in IDLE for a fresh cs_n falling edge; a still-low cs_n is not treated as a new transfer until it rises and falls again.

Verification
REQ-028 Reset release -> all matrix words = 16'h0000; frame_done = frame_err = 0; no pulses with idle SPI inputs (cs_n = 1).
REQ-029 Send 64 bytes 8'hA5, 8'h3C repeating, sck = clk/8 -> every matrix word = 16'hA53C. One frame_done pulse, 2 cycles after the last sck edge detect.
REQ-030 Send only 40 bytes of 8'hFF, then raise cs_n -> one frame_err pulse; matrix keeps its previous contents; no frame_done.
REQ-031 Send a full frame of 8'h00, then 3 extra bytes of 8'hFF before cs_n rises -> matrix all zero; exactly one frame_done; no frame_err.
REQ-032 Two back-to-back frames (all 16'h1234, then all 16'h8001) -> two frame_done pulses; matrix ends at 16'h8001 in every word; word 0 bit 15 = 1.
REQ-033 Assert reset after 30 bytes, release, then send a full frame of 8'h55 -> no frame_err; final matrix all 16'h5555.
